// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         FCNT_W   = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID-stage source that depends on a load still in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] ex_wr_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  output logic       lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1_i & (id_rs1_i == ex_wr_i);
  assign rs2_hit = use_rs2_i & (id_rs2_i == ex_wr_i);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu_o = mem_read_i & (ex_wr_i != REG_ZERO) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: load-use stalls, multi-cycle branch flushes, memory freezes
// and saturating event counters.
//
// state    | meaning
// RUN      | normal issue; branch/load-use/busy evaluated every cycle
// BR_FLUSH | extra flush cycles after a taken branch, fcnt counts remaining
// MEM_WAIT | data memory busy, back half of the pipe frozen
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_MemRead_i,
  input  logic [4:0]       id_ex_wr_i,
  input  logic [4:0]       if_id_rs1_i,
  input  logic [4:0]       if_id_rs2_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             ID_Flush,
  output logic             pipe_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] busy_cnt_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
    $error("pipe_hazard_ctrl: FLUSH_CYCLES must be in 1..4");
  end

  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  state_t            state;
  state_t            next_state;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] next_fcnt;
  logic              lu;
  logic              freeze;
  logic              do_flush;
  logic              do_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  hazard_detect u_hazard_detect (
    .mem_read_i (id_ex_MemRead_i),
    .ex_wr_i    (id_ex_wr_i),
    .id_rs1_i   (if_id_rs1_i),
    .id_rs2_i   (if_id_rs2_i),
    .use_rs1_i  (use_rs1_i),
    .use_rs2_i  (use_rs2_i),
    .lu_o       (lu)
  );

  // MEM_WAIT with busy low behaves exactly like RUN, so only BR_FLUSH is special-cased
  always_comb begin
    freeze     = 1'b0;
    do_flush   = 1'b0;
    do_stall   = 1'b0;
    next_state = state;
    next_fcnt  = fcnt;
    if (mem_busy_i) begin
      freeze = 1'b1;
      if (state != BR_FLUSH) next_state = MEM_WAIT;
    end else if (state == BR_FLUSH) begin
      do_flush  = 1'b1;
      next_fcnt = fcnt - FCNT_ONE;
      if (fcnt == FCNT_ONE) next_state = RUN;
    end else if (branch_taken_i) begin
      do_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state = BR_FLUSH;
        next_fcnt  = FCNT_INIT;
      end else begin
        next_state = RUN;
      end
    end else if (lu) begin
      do_stall   = 1'b1;
      next_state = RUN;
    end else begin
      next_state = RUN;
    end
  end

  always_comb begin
    if (!rst_n) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      pipe_en_o     = 1'b0;
      if_id_flush_o = 1'b1;
      ID_Flush      = 1'b1;
    end else begin
      pc_write_o    = ~freeze & ~do_stall;
      if_id_write_o = ~freeze & ~do_stall;
      pipe_en_o     = ~freeze;
      if_id_flush_o = do_flush;
      ID_Flush      = do_flush | do_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      fcnt        <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      busy_cnt_o  <= '0;
    end else begin
      state <= next_state;
      fcnt  <= next_fcnt;
      if (freeze)   busy_cnt_o  <= sat_inc(busy_cnt_o);
      if (do_flush) flush_cnt_o <= sat_inc(flush_cnt_o);
      if (do_stall) stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle decisions, hand sequences
// for branch flush, memory freeze, priority, reset abort and counter saturation.
module tb_pipe_hazard_ctrl;

  typedef struct {
    string      nm;
    logic       mr;
    logic [4:0] wr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       busy;
    logic [4:0] exp;   // {pc_write, if_id_write, if_id_flush, ID_Flush, pipe_en}
    logic       si;
    logic       bi;
  } vec_t;

  localparam logic [4:0] O_RUN   = 5'b11001;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11111;
  localparam logic [4:0] O_FRZ   = 5'b00000;
  localparam logic [4:0] O_RST   = 5'b00110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mr, u1, u2, br, busy;
  logic [4:0]  wr, rs1, rs2;
  logic        pc_w, ifid_w, ifid_f, id_f, pe;
  logic [31:0] stall_c, flush_c, busy_c;
  logic        pc_w2, ifid_w2, ifid_f2, id_f2, pe2;
  logic [2:0]  stall_c2, flush_c2, busy_c2;

  int n_chk  = 0;
  int n_fail = 0;
  int e_stall = 0, e_flush = 0, e_busy = 0;
  vec_t tbl[11];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_ex_MemRead_i(mr), .id_ex_wr_i(wr),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .use_rs1_i(u1), .use_rs2_i(u2),
    .branch_taken_i(br), .mem_busy_i(busy),
    .pc_write_o(pc_w), .if_id_write_o(ifid_w), .if_id_flush_o(ifid_f), .ID_Flush(id_f),
    .pipe_en_o(pe), .stall_cnt_o(stall_c), .flush_cnt_o(flush_c), .busy_cnt_o(busy_c)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_ex_MemRead_i(mr), .id_ex_wr_i(wr),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .use_rs1_i(u1), .use_rs2_i(u2),
    .branch_taken_i(br), .mem_busy_i(busy),
    .pc_write_o(pc_w2), .if_id_write_o(ifid_w2), .if_id_flush_o(ifid_f2), .ID_Flush(id_f2),
    .pipe_en_o(pe2), .stall_cnt_o(stall_c2), .flush_cnt_o(flush_c2), .busy_cnt_o(busy_c2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [4:0] exp);
    chk({nm, " outs"}, {27'd0, pc_w, ifid_w, ifid_f, id_f, pe}, {27'd0, exp});
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, " stall_cnt"}, stall_c, e_stall);
    chk({nm, " flush_cnt"}, flush_c, e_flush);
    chk({nm, " busy_cnt"},  busy_c,  e_busy);
  endtask

  // Apply inputs at the falling edge and let combinational outputs settle
  task automatic drive(input logic m, input logic [4:0] w, input logic [4:0] r1,
                       input logic [4:0] r2, input logic a1, input logic a2,
                       input logic b, input logic bz);
    @(negedge clk);
    mr = m; wr = w; rs1 = r1; rs2 = r2; u1 = a1; u2 = a2; br = b; busy = bz;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{"none",        0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, O_RUN,   0, 0};
    tbl[1]  = '{"lu_rs1",      1, 5'd5,  5'd5,  5'd3,  1, 0, 0, 0, O_STALL, 1, 0};
    tbl[2]  = '{"lu_wr0",      1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0, O_RUN,   0, 0};
    tbl[3]  = '{"lu_nouse1",   1, 5'd5,  5'd5,  5'd3,  0, 0, 0, 0, O_RUN,   0, 0};
    tbl[4]  = '{"lu_rs2",      1, 5'd7,  5'd1,  5'd7,  1, 1, 0, 0, O_STALL, 1, 0};
    tbl[5]  = '{"no_memread",  0, 5'd7,  5'd7,  5'd7,  1, 1, 0, 0, O_RUN,   0, 0};
    tbl[6]  = '{"lu_nouse2",   1, 5'd7,  5'd1,  5'd7,  1, 0, 0, 0, O_RUN,   0, 0};
    tbl[7]  = '{"busy_lu",     1, 5'd5,  5'd5,  5'd0,  1, 0, 0, 1, O_FRZ,   0, 1};
    tbl[8]  = '{"busy_hold",   0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, O_FRZ,   0, 1};
    tbl[9]  = '{"wait_exit_lu",1, 5'd5,  5'd5,  5'd0,  1, 0, 0, 0, O_STALL, 1, 0};
    tbl[10] = '{"lu_r31_both", 1, 5'd31, 5'd31, 5'd31, 1, 1, 0, 0, O_STALL, 1, 0};

    rst_n = 1'b0;
    mr = 0; wr = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; br = 0; busy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_outs("reset", O_RST);
    chk_cnts("reset");

    @(negedge clk); rst_n = 1'b1; #1;
    chk_outs("post_reset", O_RUN);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].mr, tbl[i].wr, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
            tbl[i].br, tbl[i].busy);
      chk_outs(tbl[i].nm, tbl[i].exp);
      if (tbl[i].si) e_stall++;
      if (tbl[i].bi) e_busy++;
      @(posedge clk); #1;
      chk_cnts(tbl[i].nm);
    end

    // Branch with 3 flush cycles; load-use during BR_FLUSH must be ignored
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);  chk_outs("br_c1", O_FLUSH);
    drive(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);  chk_outs("br_c2_lu", O_FLUSH);
    idle();                                   chk_outs("br_c3", O_FLUSH);
    idle();                                   chk_outs("br_done", O_RUN);
    e_flush += 3;
    chk_cnts("branch");

    // Memory freeze in the middle of BR_FLUSH holds the remaining flush count
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);  chk_outs("bw_br", O_FLUSH);
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
      chk_outs("bw_freeze", O_FRZ);
    end
    idle();                                   chk_outs("bw_rem1", O_FLUSH);
    idle();                                   chk_outs("bw_rem2", O_FLUSH);
    idle();                                   chk_outs("bw_done", O_RUN);
    e_flush += 3; e_busy += 4;
    chk_cnts("br_wait");

    // All three events: freeze wins; then held branch acts as busy drops, no stall counted
    drive(1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1);  chk_outs("prio_all", O_FRZ);
    drive(1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0);  chk_outs("prio_br", O_FLUSH);
    idle();                                   chk_outs("prio_f2", O_FLUSH);
    idle();                                   chk_outs("prio_f3", O_FLUSH);
    idle();                                   chk_outs("prio_done", O_RUN);
    e_busy += 1; e_flush += 3;
    chk_cnts("prio");

    // Reset during BR_FLUSH aborts to RUN and clears counters
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);  chk_outs("rab_br", O_FLUSH);
    @(negedge clk); rst_n = 1'b0; br = 1'b0; #1;
    chk_outs("rab_rst", O_RST);
    @(negedge clk); rst_n = 1'b1; #1;
    chk_outs("rab_run", O_RUN);
    e_stall = 0; e_flush = 0; e_busy = 0;
    chk_cnts("rab");

    // Saturation on the 3-bit instance, then single-cycle branch flush
    for (int i = 0; i < 9; i++) drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("sat busy_cnt2", {29'd0, busy_c2}, 32'd7);
    chk("nosat busy_cnt", busy_c, 32'd9);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    chk("f1 outs2", {27'd0, pc_w2, ifid_w2, ifid_f2, id_f2, pe2}, {27'd0, O_FLUSH});
    idle();
    chk("f1 done2", {27'd0, pc_w2, ifid_w2, ifid_f2, id_f2, pe2}, {27'd0, O_RUN});
    chk("f1 flush_cnt2", {29'd0, flush_c2}, 32'd1);
    chk("f3 still flushing", {27'd0, pc_w, ifid_w, ifid_f, id_f, pe}, {27'd0, O_FLUSH});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline.
- Generates PC/IF_ID write enables, IF_ID flush, the ID_Flush input of id_ex, and a freeze enable for EX_MEM/MEM_WB.
- Handles three cases: load-use stalls, taken-branch flushes (multi-cycle via counter) and data-memory wait freezes.
- Keeps saturating performance counters for each event class.

Parameters:
- FLUSH_CYCLES, 1, cycles the ID_Flush/IF_ID flush pair stays asserted per taken branch; legal range 1..4.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- id_ex_MemRead_i  input  1  instruction in EX is a load
- id_ex_wr_i  input  5  destination register of the instruction in EX
- if_id_rs1_i  input  5  rs1 of the instruction in ID
- if_id_rs2_i  input  5  rs2 of the instruction in ID
- use_rs1_i  input  1  ID instruction reads rs1
- use_rs2_i  input  1  ID instruction reads rs2
- branch_taken_i  input  1  branch/jump resolved taken in EX
- mem_busy_i  input  1  data memory not ready this cycle
- pc_write_o  output  1  PC register load enable
- if_id_write_o  output  1  IF_ID load enable
- if_id_flush_o  output  1  IF_ID clear to NOP
- ID_Flush  output  1  drives id_ex ID_Flush (bubble insert)
- pipe_en_o  output  1  EX_MEM/MEM_WB load enable
- stall_cnt_o  output  CNT_W  load-use stall cycles
- flush_cnt_o  output  CNT_W  branch flush cycles
- busy_cnt_o  output  CNT_W  memory freeze cycles

Behaviour:
- Control outputs are combinational (Mealy) from state, flush counter and inputs. Counters and FSM are registered.
- States: RUN, BR_FLUSH, MEM_WAIT.
- Load-use hit (lu) = id_ex_MemRead_i & (id_ex_wr_i != 0) & ((use_rs1_i & rs1 == wr) | (use_rs2_i & rs2 == wr)).
- Priority per cycle: mem_busy_i > branch_taken_i > lu.
- RUN, mem_busy_i=1:
  - Outputs: pc_write=0, if_id_write=0, pipe_en=0, both flushes 0.
  - Next state MEM_WAIT; busy_cnt++.
- RUN, branch_taken_i=1 (no busy):
  - Outputs: pc_write=1 (target loaded), if_id_write=1, if_id_flush=1, ID_Flush=1, pipe_en=1; flush_cnt++.
  - FLUSH_CYCLES=1: stay RUN.
  - FLUSH_CYCLES>1: go BR_FLUSH with fcnt=FLUSH_CYCLES-1.
- RUN, lu=1 only:
  - Outputs: pc_write=0, if_id_write=0, ID_Flush=1, if_id_flush=0, pipe_en=1; stall_cnt++.
  - Stay RUN. The hazard clears naturally the next cycle when the load leaves EX.
- RUN, none: all enables 1, flushes 0.
- BR_FLUSH:
  - Outputs: if_id_flush=1, ID_Flush=1, pc_write=1, if_id_write=1, pipe_en=1; flush_cnt++; fcnt--.
  - Return to RUN after the cycle where fcnt==1.
  - branch_taken_i and lu are ignored here, because the flushed stages hold no valid instruction.
- BR_FLUSH with mem_busy_i=1: freeze outputs as in MEM_WAIT. fcnt holds and state stays BR_FLUSH; busy_cnt++.
- MEM_WAIT:
  - Outputs: freeze as above; busy_cnt++ each cycle mem_busy_i=1.
  - When mem_busy_i drops, go RUN. That same cycle is evaluated as RUN, so a held branch_taken_i or lu acts immediately.
- Counters saturate at all-ones with no wrap. Increments are mutually exclusive per cycle.
- Reset (rst_n=0 at edge): state=RUN, fcnt=0, all counters=0.
- While rst_n=0, outputs are forced: pc_write=0, if_id_write=0, pipe_en=0, if_id_flush=1, ID_Flush=1. This flushes the pipe.
- Reset asserted mid-BR_FLUSH or mid-MEM_WAIT aborts to RUN on that edge.
- FLUSH_CYCLES outside 1..4: elaboration-time error.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, BR_FLUSH, MEM_WAIT}
  - REG_ZERO = 5'd0
  - FCNT_W = 2
- One sub-module, hazard_detect: purely combinational load-use comparator (lu output), reusable by a later forwarding unit.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> ID_Flush=1, if_id_flush=1, pc_write=0, counters 0; after release with no hazards -> all enables 1, flushes 0.
- Load-use: MemRead=1, wr=5, rs1=5, use_rs1=1 for 1 cycle -> pc_write=0, if_id_write=0, ID_Flush=1 that cycle; stall_cnt=1.
- No false hit: the same stimulus with wr=0, or use_rs1=0 -> no stall, stall_cnt stays 0.
- Branch: FLUSH_CYCLES=3, branch_taken_i pulse -> ID_Flush and if_id_flush high for exactly 3 cycles; flush_cnt=3.
- Memory wait: mem_busy_i=1 for 4 cycles during BR_FLUSH with fcnt=2 -> all enables 0 for 4 cycles, then 2 remaining flush cycles; busy_cnt=4.
- Priority: mem_busy_i, branch_taken_i and lu all asserted -> freeze only. When busy drops with branch still high -> flush that cycle and no stall counted.
